// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter signal bundle for uart_tx_arbiter.
// slave = arbiter side, master = producers plus transmitter side.
interface uart_tx_arbiter_if;
  logic       i_req0_valid;
  logic [7:0] i_req0_data;
  logic       o_req0_ready;
  logic       i_req1_valid;
  logic [7:0] i_req1_data;
  logic       o_req1_ready;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_busy;
  logic [1:0] o_grant;

  modport slave (
    input  i_req0_valid, i_req0_data,
    input  i_req1_valid, i_req1_data,
    output o_req0_ready, o_req1_ready,
    output o_tx_data, o_tx_start,
    output o_busy, o_grant
  );

  modport master (
    output i_req0_valid, i_req0_data,
    output i_req1_valid, i_req1_data,
    input  o_req0_ready, o_req1_ready,
    input  o_tx_data, o_tx_start,
    input  o_busy, o_grant
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester owner of the shared UART transmitter, frame-timed.
// Define UART_ARB_FIXED_PRIORITY_EN for fixed req0-first priority.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FRAME_BITS   = 10,
  parameter int GAP_CLKS     = 0
) (
  input logic              clk,
  input logic              i_reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS;
  localparam int CW = $clog2(FRAME_CLKS + 1);
  localparam logic [CW-1:0] FRAME_LOAD = CW'(FRAME_CLKS - 1);
  localparam logic [CW-1:0] GAP_LOAD =
    CW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE, START, FRAME, GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full0_q, full0_d;
  logic          full1_q, full1_d;
  logic [7:0]    slot0_q, slot0_d;
  logic [7:0]    slot1_q, slot1_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    grant_q, grant_d;
  logic          pick0, pick1;

`ifdef UART_ARB_FIXED_PRIORITY_EN
  always_comb begin
    pick0 = full0_q;
    pick1 = full1_q && !full0_q;
  end
`else
  logic last1_q, last1_d;

  // last1_q set means req1 owned the previous frame
  always_comb begin
    pick0 = full0_q && (!full1_q || last1_q);
    pick1 = full1_q && !pick0;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    full0_d = full0_q;
    full1_d = full1_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    data_d  = data_q;
    grant_d = grant_q;
`ifndef UART_ARB_FIXED_PRIORITY_EN
    last1_d = last1_q;
`endif
    if (bus.i_req0_valid && !full0_q) begin
      full0_d = 1'b1;
      slot0_d = bus.i_req0_data;
    end
    if (bus.i_req1_valid && !full1_q) begin
      full1_d = 1'b1;
      slot1_d = bus.i_req1_data;
    end
    unique case (state_q)
      IDLE: begin
        if (pick0 || pick1) begin
          state_d = START;
          grant_d = {pick1, pick0};
          data_d  = pick0 ? slot0_q : slot1_q;
          if (pick0) full0_d = 1'b0;
          else       full1_d = 1'b0;
`ifndef UART_ARB_FIXED_PRIORITY_EN
          last1_d = pick1;
`endif
        end
      end
      START: begin
        state_d = FRAME;
        cnt_d   = FRAME_LOAD;
      end
      FRAME: begin
        if (cnt_q == '0) begin
          if (GAP_CLKS > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          grant_d = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      full0_q <= 1'b0;
      full1_q <= 1'b0;
      slot0_q <= '0;
      slot1_q <= '0;
      data_q  <= '0;
      grant_q <= '0;
`ifndef UART_ARB_FIXED_PRIORITY_EN
      last1_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      full0_q <= full0_d;
      full1_q <= full1_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      data_q  <= data_d;
      grant_q <= grant_d;
`ifndef UART_ARB_FIXED_PRIORITY_EN
      last1_q <= last1_d;
`endif
    end
  end

  assign bus.o_req0_ready = !full0_q;
  assign bus.o_req1_ready = !full1_q;
  assign bus.o_tx_data    = data_q;
  assign bus.o_tx_start   = (state_q == START);
  assign bus.o_busy       = (state_q != IDLE);
  assign bus.o_grant      = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic
// against a slot/countdown reference model.
module tb_uart_tx_arbiter;
  localparam int CPB   = 4;
  localparam int FB    = 10;
  localparam int GAPC  = 2;
  localparam int FRAME = CPB * FB;
  localparam int BUSY  = 1 + FRAME + GAPC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(
    .CLKS_PER_BIT(CPB),
    .FRAME_BITS  (FB),
    .GAP_CLKS    (GAPC)
  ) dut (
    .clk    (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h",
               tag, cyc, obs, exp);
    end
  endtask

  // reference model: two holding slots and a reservation countdown
  bit         m_full[2];
  logic [7:0] m_slot[2];
  int         m_last;
  int         m_rem;
  logic [1:0] m_grant;
  logic [7:0] m_data;
  bit         m_start;
  bit         acc[2];

  // producers
  bit         pv[2];
  logic [7:0] pd[2];
  int         mode[2];
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // observed transmissions
  logic [9:0] tx_log[$];
  int         start_cyc[$];
  int         busy_cnt, r0_low_cnt, r0_low_first;

  task automatic model_reset();
    m_full = '{0, 0};
    m_slot = '{8'h00, 8'h00};
    m_last = 1;
    m_rem = 0;
    m_grant = 2'b00;
    m_data = 8'h00;
    m_start = 1'b0;
    acc = '{0, 0};
  endtask

  task automatic model_edge();
    int w;
    if (rst) begin
      model_reset();
      return;
    end
    acc[0] = bus.i_req0_valid && !m_full[0];
    acc[1] = bus.i_req1_valid && !m_full[1];
    m_start = 1'b0;
    if (m_rem == 0) begin
      if (m_full[0] || m_full[1]) begin
`ifdef UART_ARB_FIXED_PRIORITY_EN
        w = m_full[0] ? 0 : 1;
`else
        if (m_full[0] && m_full[1]) w = 1 - m_last;
        else w = m_full[0] ? 0 : 1;
`endif
        m_data = m_slot[w];
        m_full[w] = 0;
        m_grant = 2'(1 << w);
        m_last = w;
        m_rem = BUSY;
        m_start = 1'b1;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) m_grant = 2'b00;
    end
    if (acc[0]) begin
      m_full[0] = 1;
      m_slot[0] = bus.i_req0_data;
    end
    if (acc[1]) begin
      m_full[1] = 1;
      m_slot[1] = bus.i_req1_data;
    end
  endtask

  task automatic drive();
    bus.i_req0_valid = pv[0];
    bus.i_req0_data  = pd[0];
    bus.i_req1_valid = pv[1];
    bus.i_req1_data  = pd[1];
  endtask

  task automatic compare();
    check("ready0", bus.o_req0_ready, !m_full[0]);
    check("ready1", bus.o_req1_ready, !m_full[1]);
    check("start", bus.o_tx_start, m_start);
    check("busy", bus.o_busy, m_rem > 0);
    check("grant", bus.o_grant, m_grant);
    check("data", bus.o_tx_data, m_data);
  endtask

  task automatic produce(input int i);
    if (acc[i]) begin
      case (mode[i])
        0: begin
          if (i == 0 && q0.size() > 0) pd[0] = q0.pop_front();
          else if (i == 1 && q1.size() > 0) pd[1] = q1.pop_front();
          else pv[i] = 0;
        end
        1: pd[i] = pd[i] + 8'd1;
        default: begin
          pv[i] = 1'($urandom_range(0, 1));
          pd[i] = 8'($urandom);
        end
      endcase
    end else if (mode[i] == 2 && !pv[i]) begin
      pv[i] = 1'($urandom_range(0, 1));
      pd[i] = 8'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    compare();
    if (bus.o_tx_start) begin
      tx_log.push_back({bus.o_grant, bus.o_tx_data});
      start_cyc.push_back(cyc);
    end
    if (bus.o_busy) busy_cnt++;
    if (!bus.o_req0_ready) begin
      if (r0_low_cnt == 0) r0_low_first = cyc;
      r0_low_cnt++;
    end
    produce(0);
    produce(1);
    drive();
  endtask

  task automatic clear_logs();
    tx_log.delete();
    start_cyc.delete();
    busy_cnt = 0;
    r0_low_cnt = 0;
    r0_low_first = -1;
    cyc = 0;
  endtask

  task automatic do_reset();
    pv = '{0, 0};
    pd = '{8'h00, 8'h00};
    mode = '{0, 0};
    q0.delete();
    q1.delete();
    drive();
    rst = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();
    clear_logs();
  endtask

  initial begin
    pv = '{0, 0};
    pd = '{8'h00, 8'h00};
    mode = '{0, 0};
    drive();
    model_reset();
    clear_logs();
    @(negedge clk);
    check("rst_ready0", bus.o_req0_ready, 1);
    check("rst_grant", bus.o_grant, 0);
    do_reset();

    // single byte from req0
    pv[0] = 1;
    pd[0] = 8'hA5;
    drive();
    repeat (60) step();
    check("single_n", tx_log.size(), 1);
    if (tx_log.size() > 0) begin
      check("single_cyc", start_cyc[0], 2);
      check("single_tx", tx_log[0], {2'b01, 8'hA5});
    end
    check("single_busy", busy_cnt, 43);
    check("single_rdy_n", r0_low_cnt, 1);
    check("single_rdy_at", r0_low_first, 1);

    // contention, req0 wins first
    do_reset();
    pv = '{1, 1};
    pd = '{8'h11, 8'h22};
    drive();
    repeat (100) step();
    check("cont_n", tx_log.size(), 2);
    if (tx_log.size() > 1) begin
      check("cont_cyc0", start_cyc[0], 2);
      check("cont_tx0", tx_log[0], {2'b01, 8'h11});
      check("cont_cyc1", start_cyc[1], 46);
      check("cont_tx1", tx_log[1], {2'b10, 8'h22});
    end

    // backlog from both producers
    do_reset();
    mode = '{1, 1};
    pv = '{1, 1};
    pd = '{8'h00, 8'h80};
    drive();
    repeat (6 * (FRAME + GAPC + 2)) step();
    check("blog_n", tx_log.size() >= 6, 1);
    if (tx_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
`ifdef UART_ARB_FIXED_PRIORITY_EN
        check("blog_tx", tx_log[i], {2'b01, 8'(i)});
`else
        if (i % 2 == 0)
          check("blog_tx", tx_log[i], {2'b01, 8'(i / 2)});
        else
          check("blog_tx", tx_log[i], {2'b10, 8'(8'h80 + i / 2)});
`endif
      end
    end
    pv[0] = 0;
    mode[0] = 0;
    drive();
    repeat (3 * (FRAME + GAPC + 2)) step();
    if (tx_log.size() > 0)
      check("drop_last", tx_log[tx_log.size() - 1][9:8], 2'b10);

    // backpressure on req0
    do_reset();
    q0.push_back(8'h02);
    pv = '{1, 1};
    pd = '{8'h01, 8'h33};
    drive();
    repeat (150) step();
    check("bp_n", tx_log.size(), 3);
    if (tx_log.size() > 2) begin
      check("bp_tx0", tx_log[0], {2'b01, 8'h01});
      check("bp_tx1", tx_log[1], {2'b10, 8'h33});
      check("bp_tx2", tx_log[2], {2'b01, 8'h02});
    end

    // reset in the middle of a frame
    do_reset();
    pv[0] = 1;
    pd[0] = 8'h5A;
    drive();
    repeat (5) step();
    pv[1] = 1;
    pd[1] = 8'h66;
    drive();
    repeat (8) step();
    check("mid_busy", bus.o_busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_start", bus.o_tx_start, 0);
    check("ar_busy", bus.o_busy, 0);
    check("ar_grant", bus.o_grant, 0);
    check("ar_data", bus.o_tx_data, 0);
    check("ar_ready0", bus.o_req0_ready, 1);
    check("ar_ready1", bus.o_req1_ready, 1);
    model_reset();
    pv = '{0, 0};
    drive();
    step();
    step();
    rst = 1'b0;
    clear_logs();
    repeat (100) step();
    check("post_rst_n", tx_log.size(), 0);

    // random traffic
    do_reset();
    mode = '{2, 2};
    repeat (1500) step();
    check("rand_some", tx_log.size() > 10, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
